ball_ctrl: RTL and testbench
============================

Name: ball_ctrl

Overview:
- Ball motion and scoring engine for the two-paddle game on the 1024x768 @ 65 MHz display.
- Advances the ball once per frame, bounces it off the top/bottom edges and the paddles, awards points on misses, and declares a winner at 15.
- Sits between the paddle/keyboard logic (paddle positions, serve) and the draw/score renderers (ball position, points, winner).

Parameters:
- H_RES, 1024, visible width in pixels
- V_RES, 768, visible height in pixels
- BALL_SIZE, 16, ball square side in pixels
- PADDLE_H, 128, paddle height in pixels
- PADDLE_W, 16, paddle width in pixels
- PADDLE1_X, 32, left x of player 1 (left) paddle
- PADDLE2_X, 976, left x of player 2 (right) paddle
- SPEED_X, 4, horizontal step per frame
- SPEED_Y, 4, vertical step per frame
- WIN_SCORE, 15, points needed to win

Ports:
- clk65MHz  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- end_of_frame  in  1  one-cycle frame tick; ball updates only on it
- serve  in  1  level; launches ball from WAIT_SERVE
- pos_of_player_1  in  10  top y of left paddle
- pos_of_player_2  in  10  top y of right paddle
- screen_idle  in  1  menu screen active
- screen_multi  in  1  two-player game screen active
- points_player_1  out  4  player 1 score
- points_player_2  out  4  player 2 score
- who_won  out  2  0 none, 1 player 1, 2 player 2, 3 unused
- x_pos_of_ball  out  11  ball left x
- y_pos_of_ball  out  11  ball top y

Behaviour:
- All outputs registered.
- Reset (rst=0, async):
  - x=504, y=376 (centre)
  - points 0, who_won 0
  - direction dx=+1, dy=+1
  - state IDLE
- States: IDLE, WAIT_SERVE, MOVE, GAME_OVER.
- IDLE:
  - ball held at centre, scores 0, who_won 0.
  - Moves to WAIT_SERVE when screen_multi=1 and screen_idle=0.
- screen_idle=1 in any state forces IDLE on the next clock (synchronous clear of scores and ball). Takes priority over every other event.
- WAIT_SERVE:
  - ball at centre.
  - serve=1 sampled on an end_of_frame cycle -> MOVE.
  - Position changes first on the following end_of_frame.
- MOVE, on each end_of_frame:
  - nx = x ± SPEED_X, ny = y ± SPEED_Y.
  - Top: ny<=0 -> y=0, dy=+.
  - Bottom: ny+BALL_SIZE>=V_RES -> y=V_RES-BALL_SIZE (752), dy=-.
  - Paddle 1 hit: dx=- and nx<=PADDLE1_X+PADDLE_W and nx+BALL_SIZE>PADDLE1_X and vertical overlap (ny+BALL_SIZE>pos1 and ny<pos1+PADDLE_H) -> x=PADDLE1_X+PADDLE_W, dx=+.
  - Paddle 2 hit: mirror case, x=PADDLE2_X-BALL_SIZE, dx=-.
  - Miss left (nx<=0, no paddle hit): player 2 +1, ball to centre, dx=- (serve toward loser), -> WAIT_SERVE.
  - Miss right (nx+BALL_SIZE>=H_RES): player 1 +1, dx=+, -> WAIT_SERVE.
  - Edge bounce and paddle hit in the same frame: both applied.
- Scoring:
  - Score saturates at 15; no wrap.
  - The increment that reaches WIN_SCORE sets who_won (1 or 2) -> GAME_OVER.
- GAME_OVER: ball frozen at centre, scores/who_won held until screen_idle=1.
- Frame ticks when not in MOVE are ignored. end_of_frame=0 -> all registers hold.
- Arithmetic is 12-bit signed internally; outputs are always clamped to 0..H_RES-1 / 0..V_RES-1.

Optional Feature:
- BALL_SPEEDUP_EN defined: each paddle hit increments the horizontal step by 1, up to 2*SPEED_X. The step resets to SPEED_X on a point or reset.
- Undefined: constant SPEED_X.

Decomposition:
- Package ball_pkg: screen/paddle/ball geometry localparams, WIN_SCORE, state enum (IDLE, WAIT_SERVE, MOVE, GAME_OVER), who_won codes.
- Sub-module ball_collide: combinational next-position, edge/paddle hit and miss flags from x, y, dx, dy and paddle positions.
- Top holds the FSM and score registers.

Test Plan:
- Reset with rst=0 -> x=504, y=376, points 0/0, who_won 0. Hold screen_idle=1 -> values unchanged for 10 frames.
- screen_multi=1, serve=1, one frame tick -> MOVE. Next tick: x=508, y=380.
- Ball at y=2, dy=-, tick -> y=0, dy=+. Following tick -> y=4.
- Ball heading left, pos_of_player_1=300, ball y=350, reaches x=48 -> dx=+, no score. Repeat with pos_of_player_1=600 -> points_player_2=1, ball at 504/376, WAIT_SERVE.
- 15 misses by player 2 -> points_player_1=15, who_won=1, ball frozen. Further ticks produce no change. screen_idle=1 -> all cleared.
- screen_idle asserted mid-rally -> next clock ball centred, scores 0.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared geometry, score limits, FSM states and helpers for the ball/score engine.
// All coordinates are 12-bit signed so off-screen candidates compare correctly.
package ball_pkg;

    typedef logic signed [11:0] coord_t;

    localparam coord_t H_RES     = 12'sd1024;
    localparam coord_t V_RES     = 12'sd768;
    localparam coord_t BALL_SIZE = 12'sd16;
    localparam coord_t PADDLE_H  = 12'sd128;
    localparam coord_t PADDLE_W  = 12'sd16;
    localparam coord_t PADDLE1_X = 12'sd32;
    localparam coord_t PADDLE2_X = 12'sd976;
    localparam coord_t SPEED_Y   = 12'sd4;

    localparam logic [3:0]  SPEED_X   = 4'd4;
    localparam logic [3:0]  MAX_STEP  = 4'd8;
    localparam logic [3:0]  WIN_SCORE = 4'd15;
    localparam logic [10:0] X_CENTRE  = 11'd504;
    localparam logic [10:0] Y_CENTRE  = 11'd376;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SERVE = 2'd1,
        ST_MOVE       = 2'd2,
        ST_GAME_OVER  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        WON_NONE = 2'd0,
        WON_P1   = 2'd1,
        WON_P2   = 2'd2
    } winner_e;

    // dx/dy: 1 = increasing coordinate (right/down), 0 = decreasing.
    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        dx;
        logic        dy;
        logic        miss_l;
        logic        miss_r;
    } collide_t;

    function automatic logic [10:0] clamp_pos(input coord_t v, input coord_t lim);
        coord_t c;
        if (v < 12'sd0)
            c = 12'sd0;
        else if (v >= lim)
            c = lim - 12'sd1;
        else
            c = v;
        return 11'(c);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == WIN_SCORE) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/ball_collide.sv
// Combinational next-position stage: steps the ball one frame, resolves edge
// and paddle bounces, and flags a miss on either side.
module ball_collide
    import ball_pkg::*;
(
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        dx,
    input  logic        dy,
    input  logic [3:0]  step_x,
    input  logic [9:0]  pos1,
    input  logic [9:0]  pos2,
    output collide_t    res
);

    coord_t nx, ny, p1, p2, x_n, y_n;
    logic   over1, over2, hit1, hit2;

    // NOTE: every output of this block gets a value on every path, otherwise latches appear.
    always_comb begin
        p1 = $signed({2'b00, pos1});
        p2 = $signed({2'b00, pos2});
        nx = dx ? $signed({1'b0, x}) + $signed({8'b0, step_x})
                : $signed({1'b0, x}) - $signed({8'b0, step_x});
        ny = dy ? $signed({1'b0, y}) + SPEED_Y
                : $signed({1'b0, y}) - SPEED_Y;

        res.dy = dy;
        y_n    = ny;
        if (ny <= 12'sd0) begin
            y_n    = 12'sd0;
            res.dy = 1'b1;
        end else if (ny + BALL_SIZE >= V_RES) begin
            y_n    = V_RES - BALL_SIZE;
            res.dy = 1'b0;
        end

        // Overlap uses the unclamped candidate so a corner hit still counts.
        over1 = (ny + BALL_SIZE > p1) && (ny < p1 + PADDLE_H);
        over2 = (ny + BALL_SIZE > p2) && (ny < p2 + PADDLE_H);
        hit1  = !dx && (nx <= PADDLE1_X + PADDLE_W) && (nx + BALL_SIZE > PADDLE1_X) && over1;
        hit2  =  dx && (nx + BALL_SIZE >= PADDLE2_X) && (nx < PADDLE2_X + PADDLE_W) && over2;

        res.dx = dx;
        x_n    = nx;
        if (hit1) begin
            x_n    = PADDLE1_X + PADDLE_W;
            res.dx = 1'b1;
        end else if (hit2) begin
            x_n    = PADDLE2_X - BALL_SIZE;
            res.dx = 1'b0;
        end

        res.miss_l = !hit1 && (nx <= 12'sd0);
        res.miss_r = !hit2 && (nx + BALL_SIZE >= H_RES);
        res.x      = clamp_pos(x_n, H_RES);
        res.y      = clamp_pos(y_n, V_RES);
    end

endmodule

// File: rtl/ball_ctrl.sv
// Ball motion / scoring FSM for the two-paddle game. Define BALL_SPEEDUP_EN to
// grow the horizontal step by one on each paddle hit (capped at twice SPEED_X).
module ball_ctrl
    import ball_pkg::*;
(
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic        end_of_frame,
    input  logic        serve,
    input  logic [9:0]  pos_of_player_1,
    input  logic [9:0]  pos_of_player_2,
    input  logic        screen_idle,
    input  logic        screen_multi,
    output logic [3:0]  points_player_1,
    output logic [3:0]  points_player_2,
    output logic [1:0]  who_won,
    output logic [10:0] x_pos_of_ball,
    output logic [10:0] y_pos_of_ball
);

    state_e      state_q, state_d;
    winner_e     won_q, won_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic [3:0]  p1_q, p1_d, p2_q, p2_d;
    logic [3:0]  step_q, step_d;
    collide_t    col;

    ball_collide u_collide (
        .x      (x_q),
        .y      (y_q),
        .dx     (dx_q),
        .dy     (dy_q),
        .step_x (step_q),
        .pos1   (pos_of_player_1),
        .pos2   (pos_of_player_2),
        .res    (col)
    );

    always_comb begin
        state_d = state_q;
        won_d   = won_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        step_d  = step_q;

        if (screen_idle) begin
            state_d = ST_IDLE;
            won_d   = WON_NONE;
            x_d     = X_CENTRE;
            y_d     = Y_CENTRE;
            dx_d    = 1'b1;
            dy_d    = 1'b1;
            p1_d    = 4'd0;
            p2_d    = 4'd0;
            step_d  = SPEED_X;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    x_d   = X_CENTRE;
                    y_d   = Y_CENTRE;
                    p1_d  = 4'd0;
                    p2_d  = 4'd0;
                    won_d = WON_NONE;
                    if (screen_multi)
                        state_d = ST_WAIT_SERVE;
                end
                ST_WAIT_SERVE: begin
                    x_d = X_CENTRE;
                    y_d = Y_CENTRE;
                    if (end_of_frame && serve)
                        state_d = ST_MOVE;
                end
                ST_MOVE: if (end_of_frame) begin
                    dy_d = col.dy;
                    if (col.miss_l || col.miss_r) begin
                        // Re-serve from the centre, heading toward the player who lost the point.
                        x_d     = X_CENTRE;
                        y_d     = Y_CENTRE;
                        step_d  = SPEED_X;
                        dx_d    = col.miss_r;
                        state_d = ST_WAIT_SERVE;
                        if (col.miss_l) begin
                            p2_d = sat_inc(p2_q);
                            if (p2_d == WIN_SCORE) begin
                                won_d   = WON_P2;
                                state_d = ST_GAME_OVER;
                            end
                        end else begin
                            p1_d = sat_inc(p1_q);
                            if (p1_d == WIN_SCORE) begin
                                won_d   = WON_P1;
                                state_d = ST_GAME_OVER;
                            end
                        end
                    end else begin
                        x_d  = col.x;
                        y_d  = col.y;
                        dx_d = col.dx;
`ifdef BALL_SPEEDUP_EN
                        // A horizontal direction flip without a miss is a paddle hit.
                        if ((col.dx != dx_q) && (step_q < MAX_STEP))
                            step_d = step_q + 4'd1;
`endif
                    end
                end
                ST_GAME_OVER: begin
                    x_d = X_CENTRE;
                    y_d = Y_CENTRE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk65MHz or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            won_q   <= WON_NONE;
            x_q     <= X_CENTRE;
            y_q     <= Y_CENTRE;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            p1_q    <= 4'd0;
            p2_q    <= 4'd0;
            step_q  <= SPEED_X;
        end else begin
            state_q <= state_d;
            won_q   <= won_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            step_q  <= step_d;
        end
    end

    assign points_player_1 = p1_q;
    assign points_player_2 = p2_q;
    assign who_won         = won_q;
    assign x_pos_of_ball   = x_q;
    assign y_pos_of_ball   = y_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl: hand-traced rallies covering edge bounces,
// paddle hits, misses, the win condition and the screen_idle clear.
module tb_ball_ctrl;

    logic        clk65MHz = 1'b0;
    logic        rst = 1'b1;
    logic        end_of_frame = 1'b0;
    logic        serve = 1'b0;
    logic [9:0]  pos_of_player_1 = '0;
    logic [9:0]  pos_of_player_2 = '0;
    logic        screen_idle = 1'b1;
    logic        screen_multi = 1'b0;
    logic [3:0]  points_player_1, points_player_2;
    logic [1:0]  who_won;
    logic [10:0] x_pos_of_ball, y_pos_of_ball;

    int checks = 0;
    int failures = 0;

    ball_ctrl dut (
        .clk65MHz        (clk65MHz),
        .rst             (rst),
        .end_of_frame    (end_of_frame),
        .serve           (serve),
        .pos_of_player_1 (pos_of_player_1),
        .pos_of_player_2 (pos_of_player_2),
        .screen_idle     (screen_idle),
        .screen_multi    (screen_multi),
        .points_player_1 (points_player_1),
        .points_player_2 (points_player_2),
        .who_won         (who_won),
        .x_pos_of_ball   (x_pos_of_ball),
        .y_pos_of_ball   (y_pos_of_ball)
    );

    always #5 clk65MHz = ~clk65MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_ball(input string tag, input int ex, input int ey);
        check({tag, ".x"}, 32'(x_pos_of_ball), ex);
        check({tag, ".y"}, 32'(y_pos_of_ball), ey);
    endtask

    task automatic check_score(input string tag, input int e1, input int e2, input int ew);
        check({tag, ".p1"}, 32'(points_player_1), e1);
        check({tag, ".p2"}, 32'(points_player_2), e2);
        check({tag, ".won"}, 32'(who_won), ew);
    endtask

    task automatic cycle(input int n);
        repeat (n) @(negedge clk65MHz);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk65MHz);
            end_of_frame = 1'b1;
            @(negedge clk65MHz);
            end_of_frame = 1'b0;
        end
    endtask

    initial begin
        #3 rst = 1'b0;
        #20;
        check_ball("reset", 504, 376);
        check_score("reset", 0, 0, 0);
        rst = 1'b1;
        tick(10);
        check_ball("idle_hold", 504, 376);
        check_score("idle_hold", 0, 0, 0);

        // Rally A: right paddle returns, top edge bounce, left paddle returns.
        pos_of_player_1 = 10'd200;
        pos_of_player_2 = 10'd600;
        screen_idle  = 1'b0;
        screen_multi = 1'b1;
        serve        = 1'b1;
        cycle(1);
        tick(1);
        check_ball("serve_tick", 504, 376);
        tick(1);
        check_ball("first_step", 508, 380);
        tick(93);
        check_ball("bottom_bounce", 880, 752);
        tick(20);
        check_ball("p2_hit", 960, 672);
        tick(1);
        check_ball("after_p2_hit", 956, 668);
        tick(166);
        check_ball("near_top", 292, 4);
        tick(1);
        check_ball("top_bounce", 288, 0);
        tick(1);
        check_ball("after_top", 284, 4);
        tick(59);
        check_ball("p1_hit", 48, 240);
        check_score("p1_hit", 0, 0, 0);
        tick(1);
        check_ball("after_p1_hit", 52, 244);

        // Mid-rally clear.
        screen_idle = 1'b1;
        cycle(1);
        check_ball("mid_clear", 504, 376);
        check_score("mid_clear", 0, 0, 0);

        // Rally B: left paddle out of the way, player 1 misses.
        screen_idle     = 1'b0;
        pos_of_player_1 = 10'd600;
        cycle(1);
        tick(1);
        tick(342);
        check_ball("p1_pass", 48, 240);
        tick(11);
        check_ball("pre_miss_l", 4, 284);
        check_score("pre_miss_l", 0, 0, 0);
        tick(1);
        check_ball("miss_l", 504, 376);
        check_score("miss_l", 0, 1, 0);
        serve = 1'b0;
        tick(3);
        check_ball("wait_no_serve", 504, 376);
        serve = 1'b1;
        tick(1);
        check_ball("reserve_tick", 504, 376);
        tick(1);
        check_ball("serve_to_loser", 500, 380);

        // Fifteen rallies that player 2 misses.
        screen_idle = 1'b1;
        cycle(1);
        check_score("clear2", 0, 0, 0);
        screen_idle     = 1'b0;
        pos_of_player_2 = 10'd300;
        cycle(1);
        tick(1);
        tick(125);
        check_ball("pre_miss_r", 1004, 628);
        tick(1);
        check_ball("miss_r", 504, 376);
        check_score("miss_r", 1, 0, 0);
        for (int r = 2; r <= 15; r++) begin
            tick(127);
            check($sformatf("rally%0d.p1", r), 32'(points_player_1), r);
        end
        check_score("game_over", 15, 0, 1);
        check_ball("game_over", 504, 376);
        tick(20);
        check_score("frozen", 15, 0, 1);
        check_ball("frozen", 504, 376);
        screen_idle = 1'b1;
        cycle(1);
        check_score("final_clear", 0, 0, 0);
        check_ball("final_clear", 504, 376);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
